// File: rtl/beep_alert_multi.sv
// Event-driven beeper: turns key/pause/finish edges into timed beep sequences.
// Optional finish reminders are compiled in with `define BEEP_REMIND_EN.
module beep_alert_multi #(
  parameter int CLK_DIV      = 50000,
  parameter int BEEP_ON      = 2,
  parameter int BEEP_OFF     = 2,
  parameter int KEY_BEEPS    = 1,
  parameter int FINISH_BEEPS = 5,
  parameter int CNT_W        = 4,
  parameter int REMIND_TICKS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             power_led,
  input  logic             pause,
  input  logic             button,
  input  logic             finish,
  output logic [CNT_W-1:0] times,
  output logic             flag_finish,
  output logic             clk_n,
  output logic             sign_led,
  output logic             busy
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(BEEP_ON - 1);
  localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(BEEP_OFF - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [PH_W-1:0]  r_ph, w_ph_nxt;
  logic [CNT_W-1:0] r_times, w_times_nxt;
  logic             r_flag, w_flag_nxt;
  logic             r_clk_n, w_clk_n_nxt;
  logic             r_seq_fin, w_seq_fin_nxt;
  logic             r_prev_pause, r_prev_button, r_prev_finish;

  logic w_tick, w_ev_finish, w_ev_key, w_remind_fire, w_start_fin, w_start_key;

`ifdef BEEP_REMIND_EN
  localparam int RM_W = (REMIND_TICKS > 1) ? $clog2(REMIND_TICKS) : 1;
  localparam logic [RM_W-1:0] RM_LAST = RM_W'(REMIND_TICKS - 1);
  logic [RM_W-1:0] r_remind, w_remind_nxt;
`endif

  assign w_tick      = (r_div == DIV_LAST);
  assign w_ev_finish = finish & ~r_prev_finish;
  assign w_ev_key    = (pause & ~r_prev_pause) | (button & ~r_prev_button);

  // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = w_tick ? '0 : r_div + 1'b1;
    w_ph_nxt      = r_ph;
    w_times_nxt   = r_times;
    w_flag_nxt    = r_flag;
    w_clk_n_nxt   = r_clk_n;
    w_seq_fin_nxt = r_seq_fin;
    w_remind_fire = 1'b0;

`ifdef BEEP_REMIND_EN
    w_remind_nxt = '0;
    if (r_state == ST_IDLE && r_flag) begin
      w_remind_nxt = r_remind;
      if (w_tick) begin
        if (r_remind == RM_LAST) begin
          w_remind_fire = 1'b1;
          w_remind_nxt  = '0;
        end else begin
          w_remind_nxt = r_remind + 1'b1;
        end
      end
    end
`else
    // Reminders compiled out; the parameter stays in the interface regardless.
    w_remind_fire = (REMIND_TICKS < 0);
`endif

    // An acknowledge clears the flag unless a finish edge takes priority.
    if (w_ev_key && !w_ev_finish) w_flag_nxt = 1'b0;

    case (r_state)
      ST_ON: begin
        if (w_tick) begin
          if (r_ph == ON_LAST) begin
            w_state_nxt = ST_OFF;
            w_ph_nxt    = '0;
            w_times_nxt = r_times - CNT_W'(1);
          end else begin
            w_ph_nxt = r_ph + 1'b1;
          end
        end
      end
      ST_OFF: begin
        if (w_tick) begin
          if (r_ph == OFF_LAST) begin
            w_ph_nxt = '0;
            if (r_times != '0) begin
              w_state_nxt = ST_ON;
            end else begin
              w_state_nxt   = ST_IDLE;
              w_seq_fin_nxt = 1'b0;
              if (r_seq_fin) w_flag_nxt = 1'b1;
            end
          end else begin
            w_ph_nxt = r_ph + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_start_fin = w_ev_finish | (w_remind_fire & ~w_ev_key);
    w_start_key = ~w_start_fin & w_ev_key & ~(r_seq_fin & (r_state != ST_IDLE));

    if (w_start_fin || w_start_key) begin
      w_state_nxt   = ST_ON;
      w_div_nxt     = '0;
      w_ph_nxt      = '0;
      w_times_nxt   = w_start_fin ? CNT_W'(FINISH_BEEPS) : CNT_W'(KEY_BEEPS);
      w_seq_fin_nxt = w_start_fin;
    end

    // Tone edge lands where the divider reaches its last count.
    if (w_state_nxt != ST_ON || w_start_fin || w_start_key) begin
      w_clk_n_nxt = 1'b0;
    end else if (r_state == ST_ON && w_div_nxt == DIV_LAST) begin
      w_clk_n_nxt = ~r_clk_n;
    end

    if (!power_led) begin
      w_state_nxt   = ST_IDLE;
      w_div_nxt     = '0;
      w_ph_nxt      = '0;
      w_times_nxt   = '0;
      w_flag_nxt    = 1'b0;
      w_clk_n_nxt   = 1'b0;
      w_seq_fin_nxt = 1'b0;
`ifdef BEEP_REMIND_EN
      w_remind_nxt  = '0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_div         <= '0;
      r_ph          <= '0;
      r_times       <= '0;
      r_flag        <= 1'b0;
      r_clk_n       <= 1'b0;
      r_seq_fin     <= 1'b0;
      r_prev_pause  <= 1'b0;
      r_prev_button <= 1'b0;
      r_prev_finish <= 1'b0;
`ifdef BEEP_REMIND_EN
      r_remind      <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_div         <= w_div_nxt;
      r_ph          <= w_ph_nxt;
      r_times       <= w_times_nxt;
      r_flag        <= w_flag_nxt;
      r_clk_n       <= w_clk_n_nxt;
      r_seq_fin     <= w_seq_fin_nxt;
      r_prev_pause  <= pause;
      r_prev_button <= button;
      r_prev_finish <= finish;
`ifdef BEEP_REMIND_EN
      r_remind      <= w_remind_nxt;
`endif
    end
  end

  assign times       = r_times;
  assign flag_finish = r_flag;
  assign clk_n       = r_clk_n;
  assign sign_led    = (r_state == ST_ON);
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_beep_alert_multi.sv
// Directed bench for beep_alert_multi with CLK_DIV=2, BEEP_ON=2, BEEP_OFF=1, KEY=1, FINISH=3.
module tb_beep_alert_multi;

`ifdef BEEP_REMIND_EN
  localparam bit REM = 1'b1;
`else
  localparam bit REM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, power_led, pause, button, finish;
  logic [3:0] times;
  logic       flag_finish, clk_n, sign_led, busy;

  int n_asserts = 0;
  int n_fail    = 0;

  beep_alert_multi #(
    .CLK_DIV(2), .BEEP_ON(2), .BEEP_OFF(1), .KEY_BEEPS(1),
    .FINISH_BEEPS(3), .CNT_W(4), .REMIND_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .power_led(power_led), .pause(pause),
    .button(button), .finish(finish), .times(times),
    .flag_finish(flag_finish), .clk_n(clk_n), .sign_led(sign_led), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input bit led, input bit bsy,
                            input bit ck, input bit flg, input logic [3:0] tm);
    n_asserts++;
    assert ({sign_led, busy, clk_n, flag_finish, times} === {led, bsy, ck, flg, tm})
    else begin
      n_fail++;
      $error("FAIL %s: observed led=%b busy=%b clk_n=%b flag=%b times=%0d, expected led=%b busy=%b clk_n=%b flag=%b times=%0d",
             tag, sign_led, busy, clk_n, flag_finish, times, led, bsy, ck, flg, tm);
    end
  endtask

  logic [6:0] e_led, e_busy, e_clk, e_tm;
  logic [3:0] rem_times;

  initial begin
    rst_n = 1'b0; power_led = 1'b1; finish = 1'b1; pause = 1'b0; button = 1'b0;
    e_led = 7'b0001111; e_busy = 7'b0111111; e_clk = 7'b0000110; e_tm = 7'b0001111;
    rem_times = REM ? 4'd3 : 4'd0;

    // Reset held with finish high: nothing starts.
    step(3);
    expect_out("reset", 0, 0, 0, 0, 4'd0);
    finish = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
    expect_out("idle_after_reset", 0, 0, 0, 0, 4'd0);

    // Single key beep.
    button = 1'b1;
    step(1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(1);
      expect_out($sformatf("key_seq_k%0d", i), e_led[i], e_busy[i], e_clk[i], 1'b0, {3'b000, e_tm[i]});
      if (i == 0) button = 1'b0;
    end

    // Three-beep finish alert, then flag.
    step(2);
    finish = 1'b1;
    step(1);
    for (int i = 0; i < 19; i++) begin
      int m;
      bit on;
      logic [3:0] tm;
      if (i > 0) step(1);
      m  = i % 6;
      on = (i < 16) && (m < 4);
      tm = (i < 4) ? 4'd3 : (i < 10) ? 4'd2 : (i < 16) ? 4'd1 : 4'd0;
      expect_out($sformatf("finish_seq_k%0d", i), on, i < 18, on && (m == 1 || m == 2), i >= 18, tm);
      if (i == 0) finish = 1'b0;
    end
    button = 1'b1;
    step(1);
    expect_out("ack_clears_flag", 1, 1, 0, 0, 4'd1);
    button = 1'b0;
    step(6);
    expect_out("ack_seq_done", 0, 0, 0, 0, 4'd0);

    // Simultaneous events: finish wins.
    finish = 1'b1; pause = 1'b1; button = 1'b1;
    step(1);
    expect_out("prio_finish", 1, 1, 0, 0, 4'd3);
    finish = 1'b0; pause = 1'b0; button = 1'b0;
    step(18);
    expect_out("prio_done", 0, 0, 0, 1, 4'd0);
    pause = 1'b1;
    step(1);
    expect_out("pause_ack", 1, 1, 0, 0, 4'd1);
    pause = 1'b0;
    step(6);
    expect_out("pause_seq_done", 0, 0, 0, 0, 4'd0);

    // Finish preempts a key sequence; later key ignored.
    button = 1'b1;
    step(1);
    expect_out("t4_key", 1, 1, 0, 0, 4'd1);
    button = 1'b0;
    step(1);
    finish = 1'b1;
    step(1);
    expect_out("t4_preempt", 1, 1, 0, 0, 4'd3);
    finish = 1'b0;
    step(2);
    button = 1'b1;
    step(1);
    expect_out("t4_key_ignored", 1, 1, 0, 0, 4'd3);
    button = 1'b0;
    step(14);
    expect_out("t4_before_flag", 0, 1, 0, 0, 4'd0);
    step(1);
    expect_out("t4_flag", 0, 0, 0, 1, 4'd0);

    // Reminder replay (or its absence) eight cycles after the flag.
    step(7);
    expect_out("remind_wait", 0, 0, 0, 1, 4'd0);
    step(1);
    expect_out("remind_replay", REM, REM, 0, 1, rem_times);
    step(18);
    expect_out("remind_done", 0, 0, 0, 1, 4'd0);
    step(2);
    pause = 1'b1;
    step(1);
    expect_out("ack_before_remind", 1, 1, 0, 0, 4'd1);
    pause = 1'b0;
    step(5);
    expect_out("remind_suppressed", 0, 1, 0, 0, 4'd0);
    step(2);
    expect_out("remind_idle", 0, 0, 0, 0, 4'd0);

    // Power loss aborts a finish sequence.
    finish = 1'b1;
    step(1);
    expect_out("t5_start", 1, 1, 0, 0, 4'd3);
    step(6);
    power_led = 1'b0;
    step(1);
    expect_out("t5_power_off", 0, 0, 0, 0, 4'd0);
    step(3);
    expect_out("t5_off_hold", 0, 0, 0, 0, 4'd0);
    power_led = 1'b1;
    step(2);
    expect_out("t5_no_spurious", 0, 0, 0, 0, 4'd0);
    finish = 1'b0;
    step(1);
    finish = 1'b1;
    step(1);
    expect_out("t5_restart", 1, 1, 0, 0, 4'd3);
    finish = 1'b0;
    step(18);
    expect_out("t5_flag", 0, 0, 0, 1, 4'd0);
    power_led = 1'b0;
    step(1);
    expect_out("power_clears_flag", 0, 0, 0, 0, 4'd0);
    power_led = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
